// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder: format codes,
// the canonical NOP and the legal immediate ranges per format.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -1048576;
  localparam int signed IMM_J_MAX = 1048574;

  function automatic logic in_range(input logic [31:0] v, input int signed lo,
                                    input int signed hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_buf.sv
// Two-entry output buffer for encoded words. Ready depends only on the
// registered occupancy, so there is no combinational path from pop to push.
module inst_buf #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign push_ready = (cnt_q != 2'd2);
  assign pop_valid  = (cnt_q != 2'd0);
  assign pop_data   = head_q;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      // push is only possible below full, so here exactly one entry is held
      2'b11: head_d = push_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= RST_DATA;
      tail_q <= RST_DATA;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs a field set into a 32-bit word, flags
// encoding faults, tags it with an IMEM byte address and buffers it.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       count
);

  localparam int                W         = 32 + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [W-1:0]      RST_DATA = {32'h0, BASE, 1'b0};

  logic [31:0]       enc_instr;
  logic              enc_err;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              accept;
  logic [W-1:0]      buf_out;

  always_comb begin
    enc_instr = NOP_INSTR;
    enc_err   = 1'b0;
    case (fmt)
      FMT_R: enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err   = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err   = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
      end
      FMT_U: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_err   = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err   = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
      end
      default: enc_err = 1'b1;
    endcase
    // every RV32 base opcode ends in 2'b11; a bad one still encodes as given
    if (opcode[1:0] != 2'b11) enc_err = 1'b1;
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (accept) addr_d = addr_q + ADDR_W'(4);
    if (out_valid && out_ready && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= BASE;
      count_q <= 16'd0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  inst_buf #(
    .W        (W),
    .RST_DATA (RST_DATA)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  ({enc_instr, addr_q, enc_err}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (buf_out)
  );

  assign out_instr = buf_out[W-1 -: 32];
  assign out_addr  = buf_out[ADDR_W:1];
  assign out_err   = buf_out[0];
  assign count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: two instances (ADDR_W=10 and ADDR_W=4)
// share stimulus; each has its own expected queue and monitor.
module tb_inst_encoder;

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [15:0] count;

  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [15:0] count4;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_addr = 0;
  exp_t q10[$];
  exp_t q4[$];
  exp_t e10, e4;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .count(count)
  );

  inst_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
    .out_addr(out_addr4), .out_err(out_err4), .count(count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q10.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out10: got 0x%08h, want no output", out_instr);
      end else begin
        e10 = q10.pop_front();
        $display("tx w10 %s: instr=0x%08h addr=%0d err=%0b", e10.name, out_instr, out_addr, out_err);
        chk({e10.name, "_instr"}, out_instr, e10.instr);
        chk({e10.name, "_addr"}, 32'(out_addr), 32'(e10.addr) & 32'h3FF);
        chk({e10.name, "_err"}, 32'(out_err), 32'(e10.err));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out4: got 0x%08h, want no output", out_instr4);
      end else begin
        e4 = q4.pop_front();
        $display("tx w4  %s: instr=0x%08h addr=%0d err=%0b", e4.name, out_instr4, out_addr4, out_err4);
        chk({e4.name, "_instr4"}, out_instr4, e4.instr);
        chk({e4.name, "_addr4"}, 32'(out_addr4), 32'(e4.addr) & 32'hF);
        chk({e4.name, "_err4"}, 32'(out_err4), 32'(e4.err));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    q10.delete();
    q4.delete();
    exp_addr = 0;
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name, input logic [31:0] ei, input logic ee);
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.name = name; e.instr = ei; e.addr = exp_addr; e.err = ee;
        q10.push_back(e);
        q4.push_back(e);
        exp_addr += 4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL %s_accept: got in_ready=0 for 50 cycles, want accept", name);
    in_valid = 1'b0;
  endtask

  task automatic send(input string name, input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] ei, input logic ee);
    drive(f, op, d, s1, s2, f3, f7, im);
    wait_accept(name, ei, ee);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (q10.size() == 0 && q4.size() == 0) break;
    end
    n_cmp++;
    if (q10.size() != 0 || q4.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d entries pending, want 0", q10.size(), q4.size());
    end
    #1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    @(posedge clk); #1 out_ready = 1'b1;
    send("addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    @(negedge clk);
    chk("addi_latency", 32'(out_valid), 32'd1);
    drain();

    do_reset();
    send("add", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
    send("sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
    send("beq", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0);
    send("i_2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1);
    send("fmt7", 3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
    send("b_odd", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00208163, 1'b1);
    send("lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send("jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0);
    send("bad_op", 3'd1, 7'h10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500090, 1'b1);
    drain();
    @(negedge clk);
    chk("count_9", 32'(count), 32'd9);

    // backpressure: two fit, the third must wait until the head drains
    @(posedge clk); #1 out_ready = 1'b0;
    send("bp1", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send("bp2", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_head_instr", out_instr, 32'h00500093);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept("bp3", 32'h0020A423, 1'b0);
    drain();
    @(negedge clk);
    chk("count_12", 32'(count), 32'd12);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // reset with two entries buffered
    @(posedge clk); #1 out_ready = 1'b0;
    send("pre_rst1", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    send("pre_rst2", 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h00700113, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_addr", 32'(out_addr), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    send("post_rst", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    drain();
    @(negedge clk);
    chk("count_1", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
